// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - FSM state encodings (idle, run, halt) and the matching enum type
//   - Default address and ROM word widths used by fetch_unit and fetch_pc_reg
package fetch_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_ROM_WIDTH  = 26;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    HALT = ST_HALT
  } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk       in  : clock, rising edge
//   rst_n     in  : asynchronous active-low reset, loads RESET_PC
//   load      in  : load load_addr (redirect); has priority over inc
//   load_addr in  : redirect target
//   inc       in  : advance by one, wrapping modulo 2^ADDR_WIDTH
//   pc        out : current program counter
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      // Natural truncation gives the modulo-2^ADDR_WIDTH wrap.
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a combinational program ROM.
// Holds the PC, drives the ROM address, captures the returned word into an
// instruction register and offers it to the decoder with valid/ready.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   start             : leave IDLE/HALT and begin fetching
//   halt_req          : stop fetching (wins over start)
//   jump_en/jump_addr : redirect the PC, flushing any presented word
//   rom_addr          : ROM address (equals pc)
//   rom_data          : ROM read data for rom_addr, same cycle
//   instr/instr_pc    : presented word and the address it came from
//   instr_valid       : instr holds an unconsumed word
//   instr_ready       : decoder accepts instr this cycle
//   fetch_count       : words loaded since reset (wrapping)
//   running           : state is RUN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ROM_WIDTH  = DEFAULT_ROM_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]  rom_data,
  output logic [ROM_WIDTH-1:0]  instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           fetch_count,
  output logic                  running
);

  state_t                state;
  state_t                state_next;
  logic                  load;
  logic [ADDR_WIDTH-1:0] pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; halt_req always wins over start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALT: if (start && !halt_req) state_next = RUN;
      RUN:        if (halt_req)           state_next = HALT;
      default:    state_next = IDLE;
    endcase
  end

  // A new word may enter the register when it is empty or being drained this
  // cycle, which is what gives back-to-back delivery with ready held high.
  assign load = (state == RUN) && !halt_req && !jump_en &&
                (!instr_valid || instr_ready);

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (jump_en),
    .load_addr (jump_addr),
    .inc       (load),
    .pc        (pc)
  );

  assign rom_addr = pc;
  assign running  = (state == RUN);

  // Instruction register, valid flag and load counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (load) begin
        instr       <= rom_data;
        instr_pc    <= pc;
        fetch_count <= fetch_count + 32'd1;
      end

      // A jump flushes the presented word; a handshake on the same edge is
      // still treated as consumed by the decoder.
      if (jump_en) begin
        instr_valid <= 1'b0;
      end else if (load) begin
        instr_valid <= 1'b1;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int AW = 16;
  localparam int RW = 26;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_data;
  logic [RW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [31:0]   fetch_count;
  logic          running;
  logic          async_probe = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Program ROM image shared by the DUT and the reference model.
  function automatic logic [RW-1:0] rom_f(input logic [AW-1:0] a);
    case (a)
      16'h0000: rom_f = 26'd1;
      16'h0001: rom_f = 26'd12;
      16'h0002: rom_f = 26'd14;
      16'h0008: rom_f = 26'h1CED;
      16'h0009: rom_f = 26'hC0FE;
      default:  rom_f = {a[9:0], a} ^ 26'h2A5A5A5;
    endcase
  endfunction

  assign rom_data = rom_f(rom_addr);

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt_req    (halt_req),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_count (fetch_count),
    .running     (running)
  );

  // Expected per-cycle view and expected accepted words.
  typedef struct {
    logic          v;
    logic          run;
    logic [31:0]   cnt;
    logic [AW-1:0] pc;
    logic [AW-1:0] ipc;
    logic [RW-1:0] ins;
  } exp_t;

  typedef struct {
    logic [AW-1:0] ipc;
    logic [RW-1:0] ins;
  } hs_t;

  exp_t cq[$];
  hs_t  hq[$];

  // Reference model: "fetching" flag, next address, one-word buffer, counter.
  bit            m_run;
  bit            m_valid;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_wpc;
  logic [31:0]   m_cnt;

  task automatic model_reset();
    m_run   = 1'b0;
    m_valid = 1'b0;
    m_pc    = '0;
    m_wpc   = '0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input bit st, input bit hr, input bit je,
                            input logic [AW-1:0] ja, input bit rd);
    bit take;
    bit ld;
    take = m_valid && rd;
    ld   = m_run && !hr && !je && (!m_valid || take);
    if (je) begin
      m_pc    = ja;
      m_valid = 1'b0;
    end else if (ld) begin
      m_wpc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 16'd1;
      m_cnt   = m_cnt + 1;
    end else if (take) begin
      m_valid = 1'b0;
    end
    if (m_run && hr)              m_run = 1'b0;
    else if (!m_run && st && !hr) m_run = 1'b1;
  endtask

  // Drive one cycle of inputs, queue what the DUT must show in this cycle,
  // then advance the model across the clock edge.
  task automatic step(input bit st, input bit hr, input bit je,
                      input logic [AW-1:0] ja, input bit rd);
    exp_t e;
    hs_t  h;
    start       = st;
    halt_req    = hr;
    jump_en     = je;
    jump_addr   = ja;
    instr_ready = rd;
    e.v   = m_valid;
    e.run = m_run;
    e.cnt = m_cnt;
    e.pc  = m_pc;
    e.ipc = m_wpc;
    e.ins = rom_f(m_wpc);
    cq.push_back(e);
    if (m_valid && rd) begin
      h.ipc = m_wpc;
      h.ins = rom_f(m_wpc);
      hq.push_back(h);
    end
    @(posedge clk);
    model_edge(st, hr, je, ja, rd);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: compares on the falling edge, plus an immediate probe right
  // after an asynchronous reset assertion.
  always @(negedge clk or posedge async_probe) begin : monitor
    exp_t e;
    hs_t  h;
    if (async_probe) begin
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", {6'd0, instr}, 32'd0);
      chk("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_running", {31'd0, running}, 32'd0);
      chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
    end else begin
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("valid", {31'd0, instr_valid}, {31'd0, e.v});
        chk("running", {31'd0, running}, {31'd0, e.run});
        chk("fetch_count", fetch_count, e.cnt);
        chk("rom_addr", {16'd0, rom_addr}, {16'd0, e.pc});
        if (e.v) begin
          chk("held_instr_pc", {16'd0, instr_pc}, {16'd0, e.ipc});
          chk("held_instr", {6'd0, instr}, {6'd0, e.ins});
        end
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        if (hq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL accept_unexpected actual=pc %h required=no word", instr_pc);
        end else begin
          h = hq.pop_front();
          chk("accept_pc", {16'd0, instr_pc}, {16'd0, h.ipc});
          chk("accept_instr", {6'd0, instr}, {6'd0, h.ins});
          $display("[TB] accept pc=%h instr=%h", instr_pc, instr);
        end
      end
    end
  end

  initial begin
    model_reset();
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Start with ready high: 1, 12, 14 back to back.
    step(1, 0, 0, '0, 1);
    repeat (4) step(0, 0, 0, '0, 1);
    // Backpressure for four cycles.
    repeat (4) step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    // Jump to 8 while a word is held unconsumed.
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, 16'h0008, 0);
    repeat (4) step(0, 0, 0, '0, 1);
    // Wrap from 0xFFFF to 0x0000.
    step(0, 0, 1, 16'hFFFF, 1);
    repeat (4) step(0, 0, 0, '0, 1);
    // Halt with the word held, then resume.
    step(0, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    repeat (3) step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 1);
    repeat (4) step(0, 0, 0, '0, 1);

    // Asynchronous reset in the middle of a cycle while running.
    #2 rst_n = 1'b0;
    #1 async_probe = 1'b1;
    #1 async_probe = 1'b0;
    start = 0; halt_req = 0; jump_en = 0; instr_ready = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 rst_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      bit st, hr, je, rd;
      logic [AW-1:0] ja;
      int sel;
      st  = ($urandom_range(0, 99) < 10);
      hr  = ($urandom_range(0, 99) < 3);
      je  = ($urandom_range(0, 99) < 8);
      rd  = ($urandom_range(0, 99) < 70);
      sel = $urandom_range(0, 3);
      if (sel < 2)       ja = 16'($urandom_range(0, 15));
      else if (sel == 2) ja = 16'($urandom_range(16'hFFF0, 16'hFFFF));
      else               ja = 16'($urandom);
      step(st, hr, je, ja, rd);
    end
    step(0, 0, 0, '0, 0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
